multi_alarm: RTL and testbench
==============================

MULTI_ALARM -- requirements
Module: multi_alarm

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4: number of alarm slots (1..8).
REQ-002 SHALL have parameter RING_SECS, default 60: auto-silence timeout in seconds (1..255).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5: snooze offset in minutes (1..59).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_2MHz  in  1  system clock, all state on rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have sec_tick  in  1  one-cycle pulse, once per second.
REQ-007 SHALL have curHH/curMM/curSS  in  7 each  current time, binary, HH 0..23, MM/SS 0..59.
REQ-008 SHALL have wr_en  in  1  slot write strobe.
REQ-009 SHALL have wr_idx  in  $clog2(N_ALARMS)  slot index.
REQ-010 SHALL have wr_time  in  21  {HH,MM,SS} to store.
REQ-011 SHALL have wr_arm  in  1  arm bit to store.
REQ-012 SHALL have btn_snooze, btn_stop  in  1 each  one-cycle button pulses.
REQ-013 SHALL have ring  out  1  alarm sounding.
REQ-014 SHALL have ring_idx  out  $clog2(N_ALARMS)  active slot; 0 when idle.
REQ-015 SHALL have snoozed  out  1  snooze pending.
REQ-016 SHALL have armed  out  N_ALARMS  per-slot arm bits.

Function
REQ-017 SHALL hold per slot a 21-bit time and an arm bit; wr_en writes both in the cycle after the strobe.
REQ-018 SHALL run FSM IDLE, RINGING, SNOOZED.
REQ-019 IDLE: on sec_tick, if any armed slot time equals {curHH,curMM,curSS}, SHALL enter RINGING with the lowest matching index; ring asserts the next cycle.
REQ-020 RINGING: SHALL count sec_ticks; on reaching RING_SECS, return to IDLE with the slot still armed.
REQ-021 RINGING + btn_snooze: SHALL enter SNOOZED and latch target = current time + SNOOZE_MIN minutes, SS unchanged, MM wrapping at 60 with carry into HH, HH wrapping at 24.
REQ-022 SNOOZED: on sec_tick matching target, SHALL re-enter RINGING for the same slot with the ring counter cleared.
REQ-023 btn_stop in RINGING or SNOOZED SHALL go to IDLE; stop wins when simultaneous with snooze.
REQ-024 Matches of other slots during RINGING/SNOOZED SHALL be ignored, not queued.
REQ-025 A wr_en to the active slot in RINGING/SNOOZED SHALL force IDLE in the same update.
REQ-026 Snooze is unlimited in count; each snooze restarts the offset from current time.
REQ-027 In IDLE the block SHALL ignore btn_snooze and btn_stop.
REQ-028 A slot stored as 21'h1FFFFF SHALL never match.

Reset
REQ-029 Reset SHALL clear all times to 21'h1FFFFF, arm bits to 0, FSM to IDLE, counters and snooze target to 0; ring=0, ring_idx=0, snoozed=0, armed=0.
REQ-030 Reset mid-ring SHALL silence ring asynchronously.

Configuration
REQ-031 SHALL use macro MULTI_ALARM_SNOOZE_EN; when defined, snooze behaves per REQ-021/022.
REQ-032 When undefined, btn_snooze SHALL be ignored, SNOOZED unreachable, snoozed tied 0, and no snooze adder or target register instantiated.

Structure
REQ-033 Package alarm_pkg SHALL hold the FSM state typedef, field width constants (7), the 24/60 limits and ALARM_OFF = 21'h1FFFFF.
REQ-034 Sub-module alarm_time_add SHALL implement combinational {HH,MM,SS} + minutes with wrap; it is instantiated only with MULTI_ALARM_SNOOZE_EN.

Verification
REQ-035 Arm slot 2 at 07:30:00, cur=07:30:00 plus sec_tick -> ring=1, ring_idx=2 next cycle.
REQ-036 Slots 1 and 3 armed at 06:00:00, match -> ring_idx=1; slot 3 is not rung afterwards.
REQ-037 Ringing, no buttons, RING_SECS=60 -> ring drops after 60th sec_tick; armed[idx] still 1.
REQ-038 Snooze at 23:58:10 -> snoozed=1, ring=0; ring returns at 00:03:10 with the same ring_idx.
REQ-039 btn_snooze and btn_stop in the same cycle while ringing -> IDLE, snoozed=0; reset asserted while ringing -> ring=0 immediately.
REQ-040 Build without MULTI_ALARM_SNOOZE_EN, press snooze while ringing -> ring stays 1, snoozed=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg -- shared types and constants for the multi_alarm block.
//   state_t        : alarm sequencer states (IDLE / RINGING / SNOOZED)
//   FIELD_W        : width of one time field (HH, MM or SS)
//   TIME_W         : packed {HH,MM,SS} width
//   HOURS_PER_DAY, MINS_PER_HOUR : wrap limits for time arithmetic
//   ALARM_OFF      : slot time value that can never match
package alarm_pkg;

  localparam int FIELD_W       = 7;
  localparam int TIME_W        = 3 * FIELD_W;
  localparam int HOURS_PER_DAY = 24;
  localparam int MINS_PER_HOUR = 60;

  localparam logic [TIME_W-1:0] ALARM_OFF = 21'h1FFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_time_add.sv
// alarm_time_add -- combinational {HH,MM,SS} + minutes with clock wrap.
// SS passes through, MM wraps at 60 carrying into HH, HH wraps at 24.
// Assumes a valid input time (MM <= 59) and an offset of at most 59 minutes,
// so a single conditional subtract per field is enough.
// Ports:
//   i_time : {HH,MM,SS} base time
//   i_min  : minutes to add (0..59)
//   o_time : {HH,MM,SS} result
module alarm_time_add
  import alarm_pkg::*;
(
  input  logic [TIME_W-1:0]  i_time,
  input  logic [FIELD_W-1:0] i_min,
  output logic [TIME_W-1:0]  o_time
);

  localparam int SUM_W = FIELD_W + 1;

  logic [FIELD_W-1:0] w_hh;
  logic [FIELD_W-1:0] w_mm;
  logic [FIELD_W-1:0] w_ss;
  logic [SUM_W-1:0]   w_mm_sum;
  logic [SUM_W-1:0]   w_hh_sum;
  logic               w_carry;
  logic [FIELD_W-1:0] w_mm_out;
  logic [FIELD_W-1:0] w_hh_out;

  assign {w_hh, w_mm, w_ss} = i_time;

  assign w_mm_sum = {1'b0, w_mm} + {1'b0, i_min};
  assign w_carry  = (w_mm_sum >= SUM_W'(MINS_PER_HOUR));
  assign w_mm_out = w_carry ? FIELD_W'(w_mm_sum - SUM_W'(MINS_PER_HOUR))
                            : w_mm_sum[FIELD_W-1:0];

  assign w_hh_sum = {1'b0, w_hh} + {{FIELD_W{1'b0}}, w_carry};
  assign w_hh_out = (w_hh_sum >= SUM_W'(HOURS_PER_DAY))
                    ? FIELD_W'(w_hh_sum - SUM_W'(HOURS_PER_DAY))
                    : w_hh_sum[FIELD_W-1:0];

  assign o_time = {w_hh_out, w_mm_out, w_ss};

endmodule

// File: rtl/multi_alarm.sv
// multi_alarm -- N-slot alarm clock sequencer with auto-silence and snooze.
// Build option: MULTI_ALARM_SNOOZE_EN enables snooze (adder + target register);
// without it btn_snooze is ignored and snoozed is tied low.
// Ports:
//   clk_2MHz, reset          : clock, asynchronous active-high reset
//   sec_tick                 : one-cycle pulse per second
//   curHH/curMM/curSS        : current time, binary
//   wr_en/wr_idx/wr_time/wr_arm : slot write port (takes effect next cycle)
//   btn_snooze, btn_stop     : one-cycle button pulses
//   ring, ring_idx           : alarm sounding and its slot (0 when idle)
//   snoozed                  : snooze pending
//   armed                    : per-slot arm bits
module multi_alarm
  import alarm_pkg::*;
#(
  parameter  int N_ALARMS   = 4,
  parameter  int RING_SECS  = 60,
  parameter  int SNOOZE_MIN = 5,
  localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk_2MHz,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [FIELD_W-1:0]  curHH,
  input  logic [FIELD_W-1:0]  curMM,
  input  logic [FIELD_W-1:0]  curSS,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [TIME_W-1:0]   wr_time,
  input  logic                wr_arm,
  input  logic                btn_snooze,
  input  logic                btn_stop,
  output logic                ring,
  output logic [IDX_W-1:0]    ring_idx,
  output logic                snoozed,
  output logic [N_ALARMS-1:0] armed
);

  localparam int CNT_W = 8;

  logic [TIME_W-1:0]   r_time [N_ALARMS];
  logic [N_ALARMS-1:0] r_arm;
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nx;
  logic [IDX_W-1:0]    w_idx_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [TIME_W-1:0]   w_now;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_active_wr;
  logic                w_snooze_req;
  logic                w_target_hit;

  assign w_now = {curHH, curMM, curSS};

  // Slot storage
  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ALARMS; i++) r_time[i] <= ALARM_OFF;
      r_arm <= '0;
    end else if (wr_en) begin
      r_time[wr_idx] <= wr_time;
      r_arm[wr_idx]  <= wr_arm;
    end
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (r_arm[i] && (r_time[i] != ALARM_OFF) && (r_time[i] == w_now)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  // A rewrite of the slot that is sounding or snoozed cancels it.
  assign w_active_wr = wr_en && (wr_idx == r_idx);

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [TIME_W-1:0] r_target;
  logic [TIME_W-1:0] w_snooze_time;

  alarm_time_add u_snooze_add (
    .i_time (w_now),
    .i_min  (FIELD_W'(SNOOZE_MIN)),
    .o_time (w_snooze_time)
  );

  assign w_snooze_req = btn_snooze;
  assign w_target_hit = sec_tick && (w_now == r_target);

  // Each snooze re-bases the target on the time of the press.
  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      r_target <= '0;
    end else if ((r_state == ST_RINGING) && (w_state_nx == ST_SNOOZED)) begin
      r_target <= w_snooze_time;
    end
  end

  assign snoozed = (r_state == ST_SNOOZED);
`else
  logic w_unused_snooze;
  assign w_unused_snooze = btn_snooze ^ SNOOZE_MIN[0];
  assign w_snooze_req    = 1'b0;
  assign w_target_hit    = 1'b0;
  assign snoozed         = 1'b0;
`endif

  // Sequencer state register
  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state logic; stop and slot rewrite take priority over snooze.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sec_tick && w_hit) begin
          w_state_nx = ST_RINGING;
          w_idx_nx   = w_hit_idx;
          w_cnt_nx   = '0;
        end
      end
      ST_RINGING: begin
        if (btn_stop || w_active_wr) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
        end else if (w_snooze_req) begin
          w_state_nx = ST_SNOOZED;
          w_cnt_nx   = '0;
        end else if (sec_tick) begin
          if (r_cnt == CNT_W'(RING_SECS - 1)) begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_SNOOZED: begin
        if (btn_stop || w_active_wr) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
        end else if (w_target_hit) begin
          w_state_nx = ST_RINGING;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = '0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign ring     = (r_state == ST_RINGING);
  assign ring_idx = r_idx;
  assign armed    = r_arm;

endmodule

// File: tb/tb_multi_alarm.sv
// tb_multi_alarm -- directed self-checking bench for multi_alarm (default
// parameters). Snooze checks follow whichever build of MULTI_ALARM_SNOOZE_EN
// the bench is compiled with.
module tb_multi_alarm;

  logic        clk_2MHz = 1'b0;
  logic        reset;
  logic        sec_tick;
  logic [6:0]  curHH, curMM, curSS;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [20:0] wr_time;
  logic        wr_arm;
  logic        btn_snooze, btn_stop;
  logic        ring;
  logic [1:0]  ring_idx;
  logic        snoozed;
  logic [3:0]  armed;

  int n_checks = 0;
  int n_err    = 0;

  multi_alarm #(.N_ALARMS(4), .RING_SECS(60), .SNOOZE_MIN(5)) dut (
    .clk_2MHz   (clk_2MHz),
    .reset      (reset),
    .sec_tick   (sec_tick),
    .curHH      (curHH),
    .curMM      (curMM),
    .curSS      (curSS),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_time    (wr_time),
    .wr_arm     (wr_arm),
    .btn_snooze (btn_snooze),
    .btn_stop   (btn_stop),
    .ring       (ring),
    .ring_idx   (ring_idx),
    .snoozed    (snoozed),
    .armed      (armed)
  );

  always #5 clk_2MHz = ~clk_2MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_2MHz);
    #1;
  endtask

  task automatic tick(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    curHH = h; curMM = m; curSS = s;
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [6:0] h, input logic [6:0] m,
                    input logic [6:0] s, input logic arm);
    wr_en = 1'b1; wr_idx = idx; wr_time = {h, m, s}; wr_arm = arm;
    step();
    wr_en = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp);
    btn_snooze = snz; btn_stop = stp;
    step();
    btn_snooze = 1'b0; btn_stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sec_tick = 1'b0;
    curHH = '0; curMM = '0; curSS = '0;
    wr_en = 1'b0; wr_idx = '0; wr_time = '0; wr_arm = 1'b0;
    btn_snooze = 1'b0; btn_stop = 1'b0;
    step(); step();
    chk("rst_ring", ring, 0);
    chk("rst_idx", ring_idx, 0);
    chk("rst_snoozed", snoozed, 0);
    chk("rst_armed", armed, 4'b0000);
    reset = 1'b0;
    step();

    // Single slot match
    wr(2, 7, 30, 0, 1);
    chk("arm2", armed, 4'b0100);
    tick(7, 29, 59);
    chk("no_match_ring", ring, 0);
    tick(7, 30, 0);
    chk("match_ring", ring, 1);
    chk("match_idx", ring_idx, 2);
    chk("match_snoozed", snoozed, 0);
    press(0, 1);
    chk("stop_ring", ring, 0);
    chk("stop_idx", ring_idx, 0);
    chk("stop_armed", armed, 4'b0100);

    // Two slots at the same time: lowest wins, other dropped
    wr(2, 7, 30, 0, 0);
    wr(1, 6, 0, 0, 1);
    wr(3, 6, 0, 0, 1);
    chk("arm13", armed, 4'b1010);
    tick(6, 0, 0);
    chk("prio_ring", ring, 1);
    chk("prio_idx", ring_idx, 1);
    tick(6, 0, 1);
    chk("prio_idx_hold", ring_idx, 1);
    press(0, 1);
    tick(6, 0, 2);
    chk("slot3_not_rung", ring, 0);
    press(1, 1);
    chk("idle_btn_ring", ring, 0);
    chk("idle_btn_snoozed", snoozed, 0);

    // Auto-silence after RING_SECS ticks
    tick(6, 0, 0);
    chk("timeout_start", ring, 1);
    for (int i = 0; i < 59; i++) tick(12, 0, 0);
    chk("tick59_ring", ring, 1);
    tick(12, 0, 0);
    chk("tick60_ring", ring, 0);
    chk("tick60_idx", ring_idx, 0);
    chk("tick60_armed", armed, 4'b1010);

    // Write to other slot keeps ringing; write to active slot forces idle
    tick(6, 0, 0);
    chk("wr_start", ring, 1);
    wr(3, 6, 0, 0, 1);
    chk("wr_other_ring", ring, 1);
    wr(1, 6, 0, 0, 1);
    chk("wr_active_ring", ring, 0);
    chk("wr_active_idx", ring_idx, 0);

    // ALARM_OFF never matches even when armed
    wr(0, 7'h7F, 7'h7F, 7'h7F, 1);
    chk("off_armed", armed, 4'b1011);
    tick(7'h7F, 7'h7F, 7'h7F);
    chk("off_no_ring", ring, 0);

    // Snooze and stop together: stop wins
    wr(2, 23, 58, 10, 1);
    tick(23, 58, 10);
    chk("both_start_idx", ring_idx, 2);
    press(1, 1);
    chk("both_ring", ring, 0);
    chk("both_snoozed", snoozed, 0);
    chk("both_idx", ring_idx, 0);

    tick(23, 58, 10);
    chk("snz_start", ring, 1);
`ifdef MULTI_ALARM_SNOOZE_EN
    press(1, 0);
    chk("snz_snoozed", snoozed, 1);
    chk("snz_ring", ring, 0);
    chk("snz_idx", ring_idx, 2);
    tick(0, 3, 9);
    chk("snz_early", ring, 0);
    tick(0, 3, 10);
    chk("snz_ret_ring", ring, 1);
    chk("snz_ret_idx", ring_idx, 2);
    chk("snz_ret_snoozed", snoozed, 0);
    for (int i = 0; i < 59; i++) tick(12, 0, 0);
    chk("snz_cnt59", ring, 1);
    tick(12, 0, 0);
    chk("snz_cnt60", ring, 0);
    tick(23, 58, 10);
    press(1, 0);
    wr(2, 23, 58, 10, 1);
    chk("snz_wr_snoozed", snoozed, 0);
    chk("snz_wr_idx", ring_idx, 0);
    tick(23, 58, 10);
`else
    press(1, 0);
    chk("nosnz_ring", ring, 1);
    chk("nosnz_snoozed", snoozed, 0);
    chk("nosnz_idx", ring_idx, 2);
`endif

    // Asynchronous reset while ringing
    chk("arst_pre", ring, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ring", ring, 0);
    chk("arst_armed", armed, 4'b0000);
    chk("arst_idx", ring_idx, 0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
